// File: rtl/systolic_pkg.sv
// Shared types and the MAC step for the systolic tile.
// SYSTOLIC_SAT_EN selects saturating accumulation; otherwise accumulation wraps.
package systolic_pkg;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_e;

  // MAC math runs at a fixed wide width and is folded back to acc_w bits.
  localparam int MAC_W = 64;
  typedef logic signed [MAC_W-1:0] mac_t;
  typedef logic signed [MAC_W:0]   mac_sum_t;

  typedef struct packed {
    mac_t acc;
    logic sat;
  } mac_res_t;

  function automatic mac_sum_t acc_max(input int acc_w);
    return (mac_sum_t'(1) <<< (acc_w - 1)) - mac_sum_t'(1);
  endfunction

  function automatic mac_sum_t acc_min(input int acc_w);
    return mac_sum_t'(0) - (mac_sum_t'(1) <<< (acc_w - 1));
  endfunction

  function automatic mac_res_t mac_step(input mac_t acc, input mac_t a, input mac_t b,
                                        input int acc_w);
    mac_res_t r;
    mac_sum_t sum;
    sum   = mac_sum_t'(acc) + mac_sum_t'(a * b);
    r.sat = 1'b0;
`ifdef SYSTOLIC_SAT_EN
    if (sum > acc_max(acc_w)) begin
      r.acc = mac_t'(acc_max(acc_w));
      r.sat = 1'b1;
    end else if (sum < acc_min(acc_w)) begin
      r.acc = mac_t'(acc_min(acc_w));
      r.sat = 1'b1;
    end else begin
      r.acc = mac_t'(sum);
    end
`else
    // sign-fold to acc_w bits: modulo 2^acc_w
    sum   = (sum <<< (MAC_W + 1 - acc_w)) >>> (MAC_W + 1 - acc_w);
    r.acc = mac_t'(sum);
`endif
    return r;
  endfunction

endpackage

// File: rtl/systolic_tile_if.sv
// Command, operand and result ports of the systolic tile.
interface systolic_tile_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int K_W    = 8
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                         start;
  logic [K_W-1:0]               k_len;
  logic                         busy;
  logic                         done;
  logic [ROWS-1:0][DATA_W-1:0]  a_west;
  logic                         a_valid;
  logic                         a_ready;
  logic [COLS-1:0][DATA_W-1:0]  b_north;
  logic                         b_valid;
  logic                         b_ready;
  logic [COLS-1:0][ACC_W-1:0]   c_south;
  logic [ROW_W-1:0]             c_row;
  logic                         c_valid;
  logic                         c_ready;
  logic                         sat_flag;

  modport master (
    output start, k_len, a_west, a_valid, b_north, b_valid, c_ready,
    input  busy, done, a_ready, b_ready, c_south, c_row, c_valid, sat_flag
  );

  modport slave (
    input  start, k_len, a_west, a_valid, b_north, b_valid, c_ready,
    output busy, done, a_ready, b_ready, c_south, c_row, c_valid, sat_flag
  );
endinterface

// File: rtl/systolic_pe.sv
// One processing element: tick-gated a/b forwarding and a MAC accumulator.
// Saturation behaviour follows SYSTOLIC_SAT_EN through mac_step.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_vld_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_vld_out,
  output logic [ACC_W-1:0]  acc,
  output logic              sat
);
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              av_q, av_d, bv_q, bv_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;
  mac_res_t          mac;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    av_d  = av_q;
    bv_d  = bv_q;
    acc_d = acc_q;
    sat_d = sat_q;
    mac   = mac_step(mac_t'($signed(acc_q)), mac_t'($signed(a_in)), mac_t'($signed(b_in)), ACC_W);
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      av_d  = 1'b0;
      bv_d  = 1'b0;
      acc_d = '0;
      sat_d = 1'b0;
    end else if (tick) begin
      a_d  = a_in;
      b_d  = b_in;
      av_d = a_vld_in;
      bv_d = b_vld_in;
      if (a_vld_in && b_vld_in) begin
        acc_d = mac.acc[ACC_W-1:0];
        sat_d = sat_q | mac.sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      av_q  <= 1'b0;
      bv_q  <= 1'b0;
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      av_q  <= av_d;
      bv_q  <= bv_d;
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign a_out     = a_q;
  assign a_vld_out = av_q;
  assign b_out     = b_q;
  assign b_vld_out = bv_q;
  assign acc       = acc_q;
  assign sat       = sat_q;
endmodule

// File: rtl/systolic_tile.sv
// ROWS x COLS output-stationary matmul tile: input skew, PE grid, FSM, row drain.
// SYSTOLIC_SAT_EN enables saturating accumulation and a live sat_flag.
module systolic_tile
  import systolic_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int K_W    = 8
) (
  input logic            clk,
  input logic            rst,
  systolic_tile_if.slave bus
);
  localparam int FLUSH_N = ROWS + COLS - 2;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W   = (K_W > $clog2(FLUSH_N + 1)) ? K_W : $clog2(FLUSH_N + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             done_q, done_d;
  logic             clr, fire, tick;

  logic [DATA_W-1:0] a_h  [ROWS][COLS+1];
  logic              av_h [ROWS][COLS+1];
  logic [DATA_W-1:0] b_v  [ROWS+1][COLS];
  logic              bv_v [ROWS+1][COLS];
  logic [ACC_W-1:0]  acc_arr [ROWS][COLS];
  logic [ROWS-1:0][COLS-1:0] sat_arr;

  assign fire = (state_q == S_FEED) && bus.a_valid && bus.b_valid;
  assign tick = fire || (state_q == S_FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    row_d   = row_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.start && bus.k_len != '0) begin
        state_d = S_FEED;
        k_d     = bus.k_len;
        cnt_d   = '0;
        row_d   = '0;
        clr     = 1'b1;
      end
      S_FEED: if (fire) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_W'(k_q)) begin
          cnt_d   = '0;
          state_d = (FLUSH_N == 0) ? S_DRAIN : S_FLUSH;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(FLUSH_N - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (bus.c_ready) begin
        if (row_q == ROW_W'(ROWS - 1)) begin
          state_d = S_IDLE;
          row_d   = '0;
          done_d  = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q != S_IDLE);
    bus.a_ready = (state_q == S_FEED);
    bus.b_ready = (state_q == S_FEED);
    bus.c_valid = (state_q == S_DRAIN);
    bus.done    = done_q;
    bus.c_row   = row_q;
    bus.c_south = '0;
    if (state_q == S_DRAIN)
      for (int j = 0; j < COLS; j++) bus.c_south[j] = acc_arr[row_q][j];
  end

`ifdef SYSTOLIC_SAT_EN
  assign bus.sat_flag = |sat_arr;
`else
  assign bus.sat_flag = 1'b0;
`endif

  // Lane i of A is delayed i ticks; flush ticks inject zero, invalid operands.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    logic [DATA_W-1:0] in_dat;
    assign in_dat = fire ? bus.a_west[i] : '0;
    if (i == 0) begin : g_direct
      assign a_h[0][0]  = in_dat;
      assign av_h[0][0] = fire;
    end else begin : g_sr
      logic [i-1:0][DATA_W-1:0] sr_q, sr_d;
      logic [i-1:0]             sv_q, sv_d;
      always_comb begin
        sr_d = sr_q;
        sv_d = sv_q;
        if (clr) begin
          sr_d = '0;
          sv_d = '0;
        end else if (tick) begin
          sr_d[0] = in_dat;
          sv_d[0] = fire;
          for (int k = 1; k < i; k++) begin
            sr_d[k] = sr_q[k-1];
            sv_d[k] = sv_q[k-1];
          end
        end
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          sr_q <= '0;
          sv_q <= '0;
        end else begin
          sr_q <= sr_d;
          sv_q <= sv_d;
        end
      end
      assign a_h[i][0]  = sr_q[i-1];
      assign av_h[i][0] = sv_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    logic [DATA_W-1:0] in_dat;
    assign in_dat = fire ? bus.b_north[j] : '0;
    if (j == 0) begin : g_direct
      assign b_v[0][0]  = in_dat;
      assign bv_v[0][0] = fire;
    end else begin : g_sr
      logic [j-1:0][DATA_W-1:0] sr_q, sr_d;
      logic [j-1:0]             sv_q, sv_d;
      always_comb begin
        sr_d = sr_q;
        sv_d = sv_q;
        if (clr) begin
          sr_d = '0;
          sv_d = '0;
        end else if (tick) begin
          sr_d[0] = in_dat;
          sv_d[0] = fire;
          for (int k = 1; k < j; k++) begin
            sr_d[k] = sr_q[k-1];
            sv_d[k] = sv_q[k-1];
          end
        end
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          sr_q <= '0;
          sv_q <= '0;
        end else begin
          sr_q <= sr_d;
          sv_q <= sv_d;
        end
      end
      assign b_v[0][j]  = sr_q[j-1];
      assign bv_v[0][j] = sv_q[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .clr       (clr),
        .a_in      (a_h[i][j]),
        .a_vld_in  (av_h[i][j]),
        .b_in      (b_v[i][j]),
        .b_vld_in  (bv_v[i][j]),
        .a_out     (a_h[i][j+1]),
        .a_vld_out (av_h[i][j+1]),
        .b_out     (b_v[i+1][j]),
        .b_vld_out (bv_v[i+1][j]),
        .acc       (acc_arr[i][j]),
        .sat       (sat_arr[i][j])
      );
    end
  end
endmodule

// File: tb/tb_systolic_tile.sv
// Directed, table-driven bench for the 4x4 systolic tile.
module tb_systolic_tile;
  localparam int ROWS = 4, COLS = 4, DATA_W = 16, ACC_W = 32, K_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_tile_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W)) bus ();

  systolic_tile #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int k;
    int a[4];
    int b[4];
    bit step;      // beat n drives a[i]+n and b[j]+n
    int c[4][4];
    int lat;       // start-to-done cycles with valids held and no stall
    bit sat;
  } vec_t;

  vec_t vecs[5];
  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  task automatic idle_inputs();
    bus.start   = 1'b0;
    bus.k_len   = '0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.c_ready = 1'b0;
    bus.a_west  = '0;
    bus.b_north = '0;
  endtask

  task automatic run_job(input int v, input bit tog, input int stall_row, input bit poke);
    vec_t x;
    int fires, guard, exp_lat;
    x = vecs[v];
    bus.start = 1'b1;
    bus.k_len = K_W'(x.k);
    t = 0;
    step();
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    fires = 0;
    guard = 0;
    while (fires < x.k && guard < 100) begin
      for (int i = 0; i < ROWS; i++) bus.a_west[i] = DATA_W'(x.a[i] + (x.step ? fires : 0));
      for (int j = 0; j < COLS; j++) bus.b_north[j] = DATA_W'(x.b[j] + (x.step ? fires : 0));
      bus.a_valid = tog ? ~guard[0] : 1'b1;
      bus.b_valid = 1'b1;
      if (poke && guard == 1) begin
        bus.start = 1'b1;
        bus.k_len = K_W'(5);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.a_ready && bus.a_valid && bus.b_valid) fires++;
      step();
      guard++;
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.start   = 1'b0;
    chk("feed_fires", fires, x.k);
    chk("a_ready_after_feed", bus.a_ready, 0);
    guard = 0;
    while (!bus.c_valid && guard < 50) begin
      step();
      guard++;
    end
    chk("drain_reached", bus.c_valid, 1);
    for (int r = 0; r < ROWS; r++) begin
      if (r == stall_row) begin
        bus.c_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          chk("stall_c_row", bus.c_row, r);
          chk("stall_c_south0", $signed(bus.c_south[0]), x.c[r][0]);
          chk("stall_c_south3", $signed(bus.c_south[3]), x.c[r][3]);
          step();
        end
      end
      bus.c_ready = 1'b1;
      chk("c_valid", bus.c_valid, 1);
      chk("c_row", bus.c_row, r);
      for (int j = 0; j < COLS; j++) chk($sformatf("c_south_v%0d_r%0d_c%0d", v, r, j),
                                         $signed(bus.c_south[j]), x.c[r][j]);
      step();
    end
    bus.c_ready = 1'b0;
    exp_lat = x.lat + (tog ? x.k - 1 : 0) + (stall_row >= 0 ? 3 : 0);
    chk("done_pulse", bus.done, 1);
    chk("done_latency", t, exp_lat);
    chk("sat_flag", bus.sat_flag, x.sat);
    step();
    chk("done_one_cycle", bus.done, 0);
    chk("busy_back_idle", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v2c;
    idle_inputs();
    rst = 1'b1;

    vecs[0].k = 1; vecs[0].a = '{1, 2, 3, 4}; vecs[0].b = '{10, 20, 30, 40};
    vecs[0].step = 1'b0; vecs[0].lat = 12; vecs[0].sat = 1'b0;
    vecs[0].c = '{'{10, 20, 30, 40}, '{20, 40, 60, 80}, '{30, 60, 90, 120}, '{40, 80, 120, 160}};

    vecs[1].k = 3; vecs[1].a = '{1, -1, 2, 0}; vecs[1].b = '{5, 6, 7, -8};
    vecs[1].step = 1'b1; vecs[1].lat = 14; vecs[1].sat = 1'b0;
    vecs[1].c = '{'{38, 44, 50, -40}, '{2, 2, 2, 2}, '{56, 65, 74, -61}, '{20, 23, 26, -19}};

`ifdef SYSTOLIC_SAT_EN
    v2c = 32'h7FFF_FFFF;
    vecs[2].sat = 1'b1;
`else
    v2c = 32'h8000_0000;
    vecs[2].sat = 1'b0;
`endif
    vecs[2].k = 2; vecs[2].a = '{-32768, -32768, -32768, -32768};
    vecs[2].b = '{-32768, -32768, -32768, -32768};
    vecs[2].step = 1'b0; vecs[2].lat = 13;

    vecs[3].k = 1; vecs[3].a = '{2, 2, 2, 2}; vecs[3].b = '{2, 2, 2, 2};
    vecs[3].step = 1'b0; vecs[3].lat = 12; vecs[3].sat = 1'b0;

    vecs[4].k = 8; vecs[4].a = '{1, 1, 1, 1}; vecs[4].b = '{1, 1, 1, 1};
    vecs[4].step = 1'b0; vecs[4].lat = 19; vecs[4].sat = 1'b0;

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        vecs[2].c[i][j] = v2c;
        vecs[3].c[i][j] = 4;
        vecs[4].c[i][j] = 8;
      end

    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_a_ready", bus.a_ready, 0);
    chk("rst_b_ready", bus.b_ready, 0);
    chk("rst_c_valid", bus.c_valid, 0);
    chk("rst_sat_flag", bus.sat_flag, 0);
    chk("rst_c_south_nonzero", (bus.c_south != '0), 0);
    chk("rst_c_row", bus.c_row, 0);
    rst = 1'b0;
    step();

    run_job(0, 1'b0, -1, 1'b0);
    run_job(1, 1'b0, -1, 1'b1);
    run_job(2, 1'b0, -1, 1'b0);
    run_job(3, 1'b0, -1, 1'b0);
    run_job(4, 1'b1, -1, 1'b0);
    run_job(0, 1'b0, 1, 1'b0);

    // k_len = 0 must not start a job
    bus.start = 1'b1;
    bus.k_len = '0;
    step();
    bus.start = 1'b0;
    for (int s = 0; s < 4; s++) begin
      chk("k0_busy", bus.busy, 0);
      chk("k0_done", bus.done, 0);
      step();
    end

    // reset in the middle of FLUSH, then a clean job must show no residue
    bus.start = 1'b1;
    bus.k_len = K_W'(3);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < ROWS; i++) bus.a_west[i] = DATA_W'(5);
    for (int j = 0; j < COLS; j++) bus.b_north[j] = DATA_W'(5);
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    repeat (3) step();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    repeat (2) step();
    chk("pre_rst_in_flush", bus.busy && !bus.a_ready && !bus.c_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_c_valid", bus.c_valid, 0);
    chk("mid_rst_a_ready", bus.a_ready, 0);
    step();
    run_job(3, 1'b0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/systolic_tile.md
# systolic_tile

Rectangular ROWS×COLS output-stationary systolic matrix-multiply tile with internal input skewing, a command/handshake front end and a row-serial result drain. It computes C = A·B for a K-deep inner dimension, where K is set per job.
- Per job: it consumes K column-of-A / row-of-B beats, flushes the wavefront, then streams ROWS result rows south over a valid/ready port.
- It is the parametrised successor of the square `systolic_array` and sits between the operand fetch stage and the writeback buffer.

## Interface
Parameters:
- ROWS, 4: PE rows; number of A lanes and result rows.
- COLS, 4: PE columns; number of B lanes and result lanes.
- DATA_W, 16: signed operand width.
- ACC_W, 32: signed accumulator width; must be ≥ 2·DATA_W.
- K_W, 8: width of `k_len`; maximum K is 2^K_W−1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  K_W  inner dimension K; latched with `start`.
- busy  out  1  high whenever state≠IDLE.
- done  out  1  one-cycle pulse after the last result row is accepted.
- a_west  in  ROWS×DATA_W signed  A[:,k], lane i = row i.
- a_valid  in  1  A beat valid.
- a_ready  out  1  A beat ready.
- b_north  in  COLS×DATA_W signed  B[k,:], lane j = column j.
- b_valid  in  1  B beat valid.
- b_ready  out  1  B beat ready.
- c_south  out  COLS×ACC_W signed  result row C[c_row,:].
- c_row  out  $clog2(ROWS) (min 1)  index of the presented row.
- c_valid  out  1  result row valid.
- c_ready  in  1  result row ready.
- sat_flag  out  1  sticky saturation indicator; cleared at `start`.

## Operation
- States: IDLE, FEED, FLUSH, DRAIN.
- IDLE → FEED on `start` with k_len≠0.
  - Latches K, clears all accumulators, skew registers and `sat_flag`.
  - `start` with k_len=0 is ignored. `start` outside IDLE is ignored.
- FEED:
  - `a_ready` = `b_ready` = 1.
  - A beat fires when `a_valid`&&`b_valid`. A lone valid is not consumed; producers hold data.
  - Each fire is one array tick; non-fire cycles freeze the array.
  - After K fires → FLUSH, or → DRAIN if ROWS+COLS−2=0.
- FLUSH:
  - Exactly ROWS+COLS−2 cycles, each an array tick with zero, invalid operands.
  - Then → DRAIN.
- Skew: lane i of A is delayed i ticks; lane j of B is delayed j ticks, by tick-enabled shift registers carrying a per-lane valid bit.
- PE(i,j): on a tick with both incoming valids, acc += a·b. It forwards a east and b south, with valids, registered per tick.
- Arithmetic:
  - The product is full 2·DATA_W signed, sign-extended to ACC_W.
  - Default accumulate wraps modulo 2^ACC_W.
- DRAIN:
  - `c_valid`=1 and `c_south` = accumulator row `c_row`, starting at row 0.
  - `c_row` increments on each `c_valid`&&`c_ready`.
  - After row ROWS−1 is accepted → IDLE and `done` pulses.
- Reset mid-job: the next state is IDLE; accumulators, skew registers and all state are cleared, with no residue into the next job.

## Timing
- Reset values: `busy`, `done`, `a_ready`, `b_ready`, `c_valid`, `sat_flag` = 0; `c_south` = 0; `c_row` = 0.
- `start` sampled at edge t0 → `busy`=1 and FEED from cycle t0+1.
- With valids held high: FEED lasts K cycles, FLUSH lasts ROWS+COLS−2 cycles, DRAIN lasts ROWS cycles.
  - `done` is high in the cycle after the final drain handshake, which is the first IDLE cycle.
  - Start-to-done = K+ROWS+COLS−2+ROWS+1 cycles; 4×4 with K=4 gives 15.
- DRAIN backpressure: `c_south` and `c_row` remain stable while `c_valid`&&!`c_ready`.
- `a_ready`, `b_ready` and `c_valid` are functions of registered state only.

## Configuration
- `SYSTOLIC_SAT_EN` defined:
  - Accumulation saturates to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Any clamp sets `sat_flag` until the next `start` or `rst`.
- Undefined: accumulation wraps, and `sat_flag` is tied to 0.

## Structure
- `systolic_pkg`:
  - State enum.
  - Accumulator min/max constants, parametrised by ACC_W.
  - Function `mac_step(acc, a, b)` returning {acc', sat}, with the saturating/wrapping choice under the macro.
- Sub-module `systolic_pe`:
  - Tick enable, a/b plus valid in and out, accumulator, clear, sat output.
  - The tile instantiates ROWS×COLS of these by generate loops, plus the skew registers and FSM.

## Test plan
- 4×4, K=1, a=[1,2,3,4], b=[10,20,30,40] → row 2 = [30,60,90,120]; rows delivered in order 0..3; `done` 15−3 = 12 cycles after `start`.
- K=8, all a=b=1, `a_valid` toggling every other cycle, `b_valid` constant → every C=8; FEED consumes exactly 8 fires; no beat is taken while `a_valid`=0.
- DRAIN with `c_ready` low for 3 cycles on row 1 → `c_south`/`c_row` held stable; rows 0..3 each seen exactly once.
- K=2, a=b=−32768 in every lane (DATA_W=16, ACC_W=32):
  - No macro: C = −2^31 (wrap), `sat_flag`=0.
  - `SYSTOLIC_SAT_EN`: C = 2^31−1, `sat_flag`=1.
- `rst` pulsed for one cycle in FLUSH → next cycle `busy`=`c_valid`=`a_ready`=0; a fresh K=1 job (a=b=2) yields all C=4.
- `start` with k_len=0 → stays IDLE, no `done`; `start` pulsed during FEED → ignored, and the running job's results are unchanged.
